mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single RAM port between instruction fetch (i-side) and data memory (d-side) requests.
//  Sits between the pipeline caches and RAM.
//  The iwait/dwait outputs feed hazard stall/PCWrite generation.
//  Registered grant FSM; d-side has priority, with bounded i-side starvation.
// PARAMETERS
//  STARVE_MAX  4  consecutive d-grants allowed while iREN pending before a forced i-grant (>=1)
// PORTS
//  CLK       in   1   clock, rising edge
//  RST       in   1   asynchronous, active-high reset
//  iREN      in   1   instruction read request
//  iaddr     in   32  instruction address (word_t)
//  iload     out  32  instruction read data
//  iwait     out  1   i-side not yet serviced
//  dREN      in   1   data read request
//  dWEN      in   1   data write request
//  daddr     in   32  data address
//  dstore    in   32  data write value
//  dload     out  32  data read data
//  dwait     out  1   d-side not yet serviced
//  ramREN    out  1   RAM read enable
//  ramWEN    out  1   RAM write enable
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data
//  ramstate  in   2   ramstate_t: FREE, BUSY, ACCESS, ERROR
//  arb_err   out  1   sticky; set on ERROR during any grant
// BEHAVIOUR
//  States (arb_state_t): IDLE, IGNT, DGNT. RST -> IDLE, starve_cnt=0, arb_err=0.
//  IDLE: dreq=dREN|dWEN.
//   - dreq && !(iREN && starve_cnt==STARVE_MAX) -> DGNT
//   - else iREN -> IGNT
//   - else stay.
//   No RAM enables in IDLE.
//  Grant latency: a request seen in IDLE drives RAM on the next cycle. Minimum service is 2 cycles.
//  IGNT: ramREN=iREN; ramaddr=iaddr; ramWEN=0.
//  DGNT: ramREN=dREN&~dWEN; ramWEN=dWEN; ramaddr=daddr; ramstore=dstore.
//   - dREN&dWEN together is treated as a write.
//  Unused RAM outputs are 0 (ramaddr/ramstore=0 in IDLE).
//  Completion: in a grant with ramstate==ACCESS, the granted wait is 0 that cycle.
//   - Read data flows combinationally: iload/dload=ramload, else 0.
//   - Next state IDLE.
//  iwait = iREN & ~(IGNT & ACCESS); dwait = dreq & ~(DGNT & ACCESS).
//   - Both are combinational, so they equal the request under reset.
//  FREE/BUSY during a grant: hold state; outputs stable.
//  ERROR during a grant: set arb_err (cleared only by RST); hold grant and keep wait high.
//  Abort: if the granted request drops (pipeline flush) -> IDLE next cycle.
//   - RAM enables deassert the same cycle, since they are gated by the live request.
//  starve_cnt: updated only on the cycle a DGNT completes.
//   - +1 if iREN=1 that cycle; cleared if iREN=0.
//   - Cleared when an IGNT completes.
//   - Saturates at STARVE_MAX.
//  Reset mid-grant: immediate IDLE, enables 0, no completion reported.
// STRUCTURE
//  cpu_types_pkg gains typedef enum logic[1:0] {IDLE,IGNT,DGNT} arb_state_t.
//   - Reuses word_t and ramstate_t.
//  Sub-module arb_starve_counter:
//   - Saturating counter with inc/clr inputs and an at_max output.
//   - Width $clog2(STARVE_MAX+1).
// TESTING
//  1 Reset: RST=1 with iREN=1 -> state IDLE, ramREN=0, iwait=1, arb_err=0.
//  2 Lone fetch: iREN=1, iaddr=0x40. RAM ACCESS on cycle 2, ramload=0x8C010004.
//    -> iload=0x8C010004, iwait=0 in cycle 2 only.
//  3 Simultaneous: iREN=1 and dWEN=1 with daddr=0x100, dstore=0xDEAD.
//    -> DGNT first, ramWEN=1; IGNT next.
//  4 Starvation: iREN held high, dREN reasserted for 6 transfers.
//    -> 4 d-grants, then 1 i-grant, then d resumes.
//  5 Abort: in DGNT with ramstate BUSY, drop dREN.
//    -> ramREN=0 that cycle, IDLE next cycle, no dload.
//  6 Error: ramstate=ERROR in IGNT -> arb_err=1, iwait stays 1 until ACCESS; arb_err persists until RST.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, RAM handshake state and the
// memory-arbiter grant state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // RAM port status as reported by the memory model / controller.
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Which requester currently owns the RAM port.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of back-to-back data grants that were completed while an
// instruction fetch was left waiting. at_max tells the arbiter to let the
// fetch through on its next decision.
module arb_starve_counter #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int W = $clog2(STARVE_MAX + 1);
   localparam logic [W-1:0] MAX_VAL = W'(STARVE_MAX);

   logic [W-1:0] count_reg;

   // Clear wins over increment; increment stops at the ceiling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != MAX_VAL)) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign at_max = (count_reg == MAX_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data access.
// Data side wins ties, but after STARVE_MAX data grants completed with a fetch
// waiting, the fetch is granted once. RAM enables and wait flags are gated by
// the live requests, so a dropped request releases the port the same cycle.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      iREN,
   input  word_t     iaddr,
   output word_t     iload,
   output logic      iwait,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output word_t     dload,
   output logic      dwait,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      arb_err
);

   arb_state_t state_reg;
   logic       arb_err_reg;
   logic       dreq;
   logic       ram_access;
   logic       i_done;
   logic       d_done;
   logic       starve_at_max;

   assign dreq       = dREN | dWEN;
   assign ram_access = (ramstate == ACCESS);
   // A grant completes only while its request is still live.
   assign i_done     = (state_reg == IGNT) && ram_access && iREN;
   assign d_done     = (state_reg == DGNT) && ram_access && dreq;

   arb_starve_counter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk    (CLK),
      .rst    (RST),
      .inc    (d_done && iREN),
      .clr    ((d_done && !iREN) || i_done),
      .at_max (starve_at_max)
   );

   // Grant FSM plus sticky error flag; grants hold through FREE/BUSY/ERROR.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg   <= IDLE;
         arb_err_reg <= 1'b0;
      end else begin
         if ((state_reg != IDLE) && (ramstate == ERROR)) begin
            arb_err_reg <= 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (dreq && !(iREN && starve_at_max)) begin
                  state_reg <= DGNT;
               end else if (iREN) begin
                  state_reg <= IGNT;
               end
            end
            IGNT: begin
               if (!iREN || ram_access) begin
                  state_reg <= IDLE;
               end
            end
            DGNT: begin
               if (!dreq || ram_access) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // RAM port steering; everything not owned by the current grant is zero.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state_reg)
         IGNT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
         end
         DGNT: begin
            // Read+write together is a write.
            ramREN   = dREN & ~dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
         end
         default: begin
         end
      endcase
   end

   // Completion handshake back to the pipeline.
   always_comb begin
      iwait = iREN & ~((state_reg == IGNT) & ram_access);
      dwait = dreq & ~((state_reg == DGNT) & ram_access);
      iload = i_done ? ramload : '0;
      dload = d_done ? ramload : '0;
   end

   assign arb_err = arb_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, lone fetch, d-over-i priority,
// starvation release, abort, sticky error and reset during a grant.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic      CLK = 1'b0;
   logic      RST;
   logic      iREN;
   word_t     iaddr;
   word_t     iload;
   logic      iwait;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   word_t     dload;
   logic      dwait;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;
   logic      arb_err;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iload    (iload),
      .iwait    (iwait),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dload    (dload),
      .dwait    (dwait),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .arb_err  (arb_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s = %h", tag, obs);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic clear_inputs();
      iREN     = 1'b0;
      iaddr    = '0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      daddr    = '0;
      dstore   = '0;
      ramload  = '0;
      ramstate = FREE;
   endtask

   task automatic go_idle();
      clear_inputs();
      next_cycle();
      next_cycle();
   endtask

   // Expected grant order with a fetch held pending: 4 data, 1 fetch, data again.
   logic exp_is_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      clear_inputs();
      RST  = 1'b1;
      iREN = 1'b1;

      // 1: reset with a fetch pending
      #3;
      chk("t1_state",   32'(dut.state_reg), 32'(IDLE));
      chk("t1_ramREN",  32'(ramREN),  32'd0);
      chk("t1_iwait",   32'(iwait),   32'd1);
      chk("t1_arb_err", 32'(arb_err), 32'd0);
      next_cycle();
      chk("t1_ramREN_clk", 32'(ramREN), 32'd0);
      next_cycle();
      RST = 1'b0;

      // 2: lone fetch, RAM answers on the second cycle
      iREN = 1'b1; iaddr = 32'h40; ramstate = FREE;
      settle();
      chk("t2_c1_ramREN", 32'(ramREN), 32'd0);
      chk("t2_c1_iwait",  32'(iwait),  32'd1);
      next_cycle();
      ramstate = ACCESS; ramload = 32'h8C01_0004;
      settle();
      chk("t2_c2_ramREN",  32'(ramREN), 32'd1);
      chk("t2_c2_ramaddr", ramaddr,     32'h40);
      chk("t2_c2_iload",   iload,       32'h8C01_0004);
      chk("t2_c2_iwait",   32'(iwait),  32'd0);
      next_cycle();
      ramstate = FREE;
      settle();
      chk("t2_c3_iwait", 32'(iwait), 32'd1);
      chk("t2_c3_iload", iload,      32'h0);
      go_idle();

      // 3: simultaneous fetch and store, store goes first
      iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD;
      ramstate = FREE;
      settle();
      chk("t3_idle_ramWEN", 32'(ramWEN), 32'd0);
      chk("t3_idle_dwait",  32'(dwait),  32'd1);
      next_cycle();
      settle();
      chk("t3_d_ramWEN",   32'(ramWEN), 32'd1);
      chk("t3_d_ramREN",   32'(ramREN), 32'd0);
      chk("t3_d_ramaddr",  ramaddr,     32'h100);
      chk("t3_d_ramstore", ramstore,    32'hDEAD);
      chk("t3_d_dwait",    32'(dwait),  32'd1);
      next_cycle();
      ramstate = ACCESS;
      settle();
      chk("t3_d_done_dwait", 32'(dwait), 32'd0);
      chk("t3_d_done_iwait", 32'(iwait), 32'd1);
      next_cycle();
      dWEN = 1'b0; ramstate = FREE;
      settle();
      chk("t3_idle2_ramaddr", ramaddr, 32'h0);
      next_cycle();
      ramstate = ACCESS; ramload = 32'h1111_2222;
      settle();
      chk("t3_i_ramREN",  32'(ramREN), 32'd1);
      chk("t3_i_ramWEN",  32'(ramWEN), 32'd0);
      chk("t3_i_ramaddr", ramaddr,     32'h44);
      chk("t3_i_iload",   iload,       32'h1111_2222);
      chk("t3_i_iwait",   32'(iwait),  32'd0);
      next_cycle();
      go_idle();

      // 4: starvation release with fetch held high
      for (int k = 0; k < 6; k++) begin
         iREN = 1'b1; iaddr = 32'h60; dREN = 1'b1; daddr = 32'h200 + 32'(k * 4);
         ramstate = FREE;
         settle();
         next_cycle();
         ramstate = ACCESS; ramload = 32'hA000 + 32'(k);
         settle();
         if (exp_is_i[k]) begin
            chk($sformatf("t4_xfer%0d_ramaddr", k), ramaddr, 32'h60);
            chk($sformatf("t4_xfer%0d_iwait", k), 32'(iwait), 32'd0);
            chk($sformatf("t4_xfer%0d_dwait", k), 32'(dwait), 32'd1);
         end else begin
            chk($sformatf("t4_xfer%0d_ramaddr", k), ramaddr, 32'h200 + 32'(k * 4));
            chk($sformatf("t4_xfer%0d_dload", k), dload, 32'hA000 + 32'(k));
            chk($sformatf("t4_xfer%0d_iwait", k), 32'(iwait), 32'd1);
         end
         next_cycle();
      end
      go_idle();

      // 5: abort a data read while RAM is busy
      dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
      settle();
      next_cycle();
      settle();
      chk("t5_busy_ramREN",  32'(ramREN), 32'd1);
      chk("t5_busy_ramaddr", ramaddr,     32'h300);
      chk("t5_busy_dwait",   32'(dwait),  32'd1);
      next_cycle();
      dREN = 1'b0;
      settle();
      chk("t5_drop_ramREN", 32'(ramREN), 32'd0);
      chk("t5_drop_dwait",  32'(dwait),  32'd0);
      chk("t5_drop_dload",  dload,       32'h0);
      next_cycle();
      ramstate = ACCESS; ramload = 32'h1234;
      settle();
      chk("t5_after_state", 32'(dut.state_reg), 32'(IDLE));
      chk("t5_after_dload", dload,   32'h0);
      chk("t5_after_addr",  ramaddr, 32'h0);
      go_idle();

      // 6: RAM error during a fetch grant
      iREN = 1'b1; iaddr = 32'h80; ramstate = FREE;
      settle();
      next_cycle();
      ramstate = ERROR;
      settle();
      chk("t6_err1_iwait",   32'(iwait),   32'd1);
      chk("t6_err1_arb_err", 32'(arb_err), 32'd0);
      next_cycle();
      settle();
      chk("t6_err2_arb_err", 32'(arb_err), 32'd1);
      chk("t6_err2_iwait",   32'(iwait),   32'd1);
      chk("t6_err2_ramREN",  32'(ramREN),  32'd1);
      next_cycle();
      ramstate = ACCESS; ramload = 32'hCAFE;
      settle();
      chk("t6_acc_iwait", 32'(iwait), 32'd0);
      chk("t6_acc_iload", iload,      32'hCAFE);
      next_cycle();
      iREN = 1'b0; ramstate = FREE;
      settle();
      chk("t6_idle_arb_err", 32'(arb_err), 32'd1);
      next_cycle();
      settle();
      chk("t6_idle2_arb_err", 32'(arb_err), 32'd1);

      // 7: reset in the middle of a read+write (treated as write) grant
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h500; dstore = 32'hBEEF;
      settle();
      next_cycle();
      settle();
      chk("t7_grant_ramWEN",   32'(ramWEN), 32'd1);
      chk("t7_grant_ramREN",   32'(ramREN), 32'd0);
      chk("t7_grant_ramstore", ramstore,    32'hBEEF);
      RST = 1'b1;
      #1;
      chk("t7_rst_ramWEN",   32'(ramWEN),  32'd0);
      chk("t7_rst_ramstore", ramstore,     32'h0);
      chk("t7_rst_dwait",    32'(dwait),   32'd1);
      chk("t7_rst_arb_err",  32'(arb_err), 32'd0);
      next_cycle();
      RST = 1'b0;
      clear_inputs();
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
